ssp_tx_fifo_p: RTL and testbench

Parametrised transmit FIFO for the SSP block, placed between the APB-side processor write path and the SSP transmit serialiser. Processor writes are qualified by PSEL and PWRITE. The serialiser side sees a show-ahead head word and pops it with NextWord. Adds generic width and depth, fill-level and full status, and a programmable-watermark transmit interrupt.

---
 rtl/ssp_pkg.sv | 17 +
 rtl/ssp_fifo_mem.sv | 28 ++
 rtl/ssp_tx_fifo_p.sv | 102 ++++++++++
 tb/tb_ssp_tx_fifo_p.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared SSP definitions: default FIFO geometry and a ceil-log2 helper
// used by both the transmit and receive FIFOs.
package ssp_pkg;

  localparam int SSP_DATA_W     = 8;
  localparam int SSP_FIFO_DEPTH = 4;

  function automatic int ssp_clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/ssp_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read by address.
// Contents are deliberately not reset.
module ssp_fifo_mem
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int DEPTH  = SSP_FIFO_DEPTH,
  localparam int AW    = ssp_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_tx_fifo_p.sv
// SSP transmit FIFO: show-ahead circular buffer with level, full and watermark interrupt.
// Optional sticky overrun flag enabled by defining SSP_TX_OVERRUN_EN.
module ssp_tx_fifo_p
  import ssp_pkg::*;
#(
  parameter int DATA_W    = SSP_DATA_W,
  parameter int DEPTH     = SSP_FIFO_DEPTH,
  parameter int WATERMARK = 2,
  localparam int CNT_W    = ssp_clog2(DEPTH + 1)
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              NextWord,
  output logic              ValidWord,
  output logic [DATA_W-1:0] TxData,
  output logic              TxFull,
  output logic [CNT_W-1:0]  TxLevel,
  output logic              SSPTXINTR
`ifdef SSP_TX_OVERRUN_EN
  ,
  input  logic              OvrClr,
  output logic              TxOverrun
`endif
);

  localparam int AW = ssp_clog2(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  level;
  logic [DATA_W-1:0] head;
  logic              valid;
  logic              full;
  logic              write_req;
  logic              push;
  logic              pop;

  assign valid     = (level != '0);
  assign full      = (level == CNT_W'(DEPTH));
  assign pop       = NextWord & valid;
  assign write_req = PSEL & PWRITE;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign push      = write_req & (~full | pop);

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  ssp_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (PCLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (PWDATA),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign ValidWord = valid;
  assign TxFull    = full;
  assign TxLevel   = level;
  assign TxData    = valid ? head : '0;
  assign SSPTXINTR = (level <= CNT_W'(WATERMARK));

`ifdef SSP_TX_OVERRUN_EN
  logic overrun;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      overrun <= 1'b0;
    end else if (write_req & full & ~pop) begin
      overrun <= 1'b1;
    end else if (OvrClr) begin
      overrun <= 1'b0;
    end
  end

  assign TxOverrun = overrun;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo_p.sv
// Bench for ssp_tx_fifo_p: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_ssp_tx_fifo_p;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int WATERMARK = 2;
  localparam int CNT_W     = 3;

  logic              PCLK;
  logic              CLEAR_B;
  logic              PSEL;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              NextWord;
  logic              ValidWord;
  logic [DATA_W-1:0] TxData;
  logic              TxFull;
  logic [CNT_W-1:0]  TxLevel;
  logic              SSPTXINTR;
`ifdef SSP_TX_OVERRUN_EN
  logic              OvrClr;
  logic              TxOverrun;
`endif

  int n_checks;
  int n_errors;

  logic [DATA_W-1:0] model_q[$];
  logic              model_ovr;

  ssp_tx_fifo_p #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .WATERMARK (WATERMARK)
  ) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .NextWord  (NextWord),
    .ValidWord (ValidWord),
    .TxData    (TxData),
    .TxFull    (TxFull),
    .TxLevel   (TxLevel),
    .SSPTXINTR (SSPTXINTR)
`ifdef SSP_TX_OVERRUN_EN
    ,
    .OvrClr    (OvrClr),
    .TxOverrun (TxOverrun)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int lvl;
    lvl = model_q.size();
    check({tag, ".valid"}, 32'(ValidWord), 32'(lvl != 0));
    check({tag, ".level"}, 32'(TxLevel), 32'(lvl));
    check({tag, ".full"},  32'(TxFull), 32'(lvl == DEPTH));
    check({tag, ".intr"},  32'(SSPTXINTR), 32'(lvl <= WATERMARK));
    check({tag, ".data"},  32'(TxData), (lvl != 0) ? 32'(model_q[0]) : 32'd0);
`ifdef SSP_TX_OVERRUN_EN
    check({tag, ".ovr"},   32'(TxOverrun), 32'(model_ovr));
`endif
  endtask

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input string tag, input logic wr, input logic [DATA_W-1:0] d,
                       input logic nxt, input logic clr);
    bit wreq, do_pop, do_push, was_full;
    PSEL     = wr;
    PWRITE   = wr;
    PWDATA   = d;
    NextWord = nxt;
`ifdef SSP_TX_OVERRUN_EN
    OvrClr   = clr;
`endif
    @(posedge PCLK);
    wreq     = wr;
    was_full = (model_q.size() == DEPTH);
    do_pop   = nxt && (model_q.size() != 0);
    do_push  = wreq && (!was_full || do_pop);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    if (wreq && was_full && !do_pop) model_ovr = 1'b1;
    else if (clr) model_ovr = 1'b0;
    @(negedge PCLK);
    check_outputs(tag);
    $display("%s wr=%0b d=%02h nxt=%0b -> level=%0d data=%02h", tag, wr, d, nxt, TxLevel, TxData);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    model_ovr = 1'b0;
    CLEAR_B   = 1'b0;
    PSEL      = 1'b0;
    PWRITE    = 1'b0;
    PWDATA    = '0;
    NextWord  = 1'b0;
`ifdef SSP_TX_OVERRUN_EN
    OvrClr    = 1'b0;
`endif
    repeat (2) @(negedge PCLK);
    check_outputs("reset");
    CLEAR_B = 1'b1;
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill and drain
    cycle("fill1", 1'b1, 8'hA1, 1'b0, 1'b0);
    cycle("fill2", 1'b1, 8'hB2, 1'b0, 1'b0);
    check("intr_before_3rd", 32'(SSPTXINTR), 32'd1);
    cycle("fill3", 1'b1, 8'hC3, 1'b0, 1'b0);
    check("intr_after_3rd", 32'(SSPTXINTR), 32'd0);
    cycle("fill4", 1'b1, 8'hD4, 1'b0, 1'b0);
    check("full_after_4th", 32'(TxFull), 32'd1);

    // Overflow while full
    cycle("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
    check("ovf_level", 32'(TxLevel), 32'd4);
`ifdef SSP_TX_OVERRUN_EN
    check("ovr_set", 32'(TxOverrun), 32'd1);
    cycle("ovr_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovr_cleared", 32'(TxOverrun), 32'd0);
`endif

    // Drain
    check("drain_head0", 32'(TxData), 32'hA1);
    cycle("pop1", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_head1", 32'(TxData), 32'hB2);
    cycle("pop2", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_head2", 32'(TxData), 32'hC3);
    cycle("pop3", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_head3", 32'(TxData), 32'hD4);
    cycle("pop4", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", 32'(ValidWord), 32'd0);
    cycle("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push/pop at full
    for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle("pushpop_full", 1'b1, 8'h55, 1'b1, 1'b0);
    check("pushpop_level", 32'(TxLevel), 32'd4);
    check("pushpop_head", 32'(TxData), 32'h11);
    for (int i = 0; i < 3; i++) cycle("drain_old", 1'b0, 8'h00, 1'b1, 1'b0);
    check("pushpop_tail", 32'(TxData), 32'h55);
    cycle("drain_last", 1'b0, 8'h00, 1'b1, 1'b0);

    // Empty edge: pop request with a push at level 0
    cycle("empty_edge", 1'b1, 8'h77, 1'b1, 1'b0);
    check("empty_edge_level", 32'(TxLevel), 32'd1);
    check("empty_edge_data", 32'(TxData), 32'h77);
    cycle("empty_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap pointers with push/pop pairs
    for (int i = 0; i < 10; i++) begin
      logic [DATA_W-1:0] w;
      w = 8'($urandom);
      cycle("wrap_push", 1'b1, w, 1'b0, 1'b0);
      check("wrap_data", 32'(TxData), 32'(w));
      cycle("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 400; i++) begin
      bit fill_phase;
      fill_phase = ((i / 40) % 2) == 0;
      cycle("rand",
            ($urandom_range(99) < (fill_phase ? 75 : 35)),
            8'($urandom),
            ($urandom_range(99) < (fill_phase ? 35 : 75)),
            ($urandom_range(9) == 0));
    end

    // Asynchronous reset mid-cycle at level 3
    while (model_q.size() > 0) cycle("pre_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("pre_fill", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("pre_reset_level", 32'(TxLevel), 32'd3);
    PSEL = 1'b0;
    PWRITE = 1'b0;
    NextWord = 1'b0;
    @(posedge PCLK);
    #2;
    CLEAR_B = 1'b0;
    #1;
    model_q.delete();
    model_ovr = 1'b0;
    check_outputs("async_reset");
    check("async_reset_intr", 32'(SSPTXINTR), 32'd1);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    cycle("post_reset", 1'b1, 8'h9C, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
